// File: rtl/dmem_bram_port.sv
// Data-memory responder: word-organised BRAM with byte-enable stores in M,
// registered reads into W with load extraction and a one-cycle-late misalign flag.
module dmem_bram_port #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          MemWriteM,
  input  logic          MemReadM,
  input  logic [1:0]    ByteAccessM,
  input  logic [AW-1:0] ALUResultM,
  input  logic [31:0]   WriteDataM,
  input  logic [2:0]    ByteSrcW,
  output logic [31:0]   ReadDataW,
  output logic          MisalignW
);

  localparam int unsigned IW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem [DEPTH_WORDS];
  logic [IW-1:0] wordIdx;
  logic [1:0]    offM;
  logic          misM;
  logic [3:0]    laneEn;
  logic [31:0]   laneData;
  logic          storeEn;
  logic          loadEn;
  logic [31:0]   rawW;
  logic [1:0]    offW;
  logic [7:0]    byteVal;
  logic [15:0]   halfVal;
  logic          unusedAddr;

  assign wordIdx    = ALUResultM[IW+1:2];
  assign offM       = ALUResultM[1:0];
  assign unusedAddr = ^ALUResultM[AW-1:IW+2];

  // Alignment check and store lane steering
  always_comb begin
    misM     = 1'b0;
    laneEn   = 4'b0000;
    laneData = 32'h0;
    case (ByteAccessM)
      2'b00: begin
        laneEn   = 4'(4'b0001 << offM);
        laneData = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        misM     = offM[0];
        laneEn   = offM[1] ? 4'b1100 : 4'b0011;
        laneData = {2{WriteDataM[15:0]}};
      end
      2'b10: begin
        misM     = (offM != 2'b00);
        laneEn   = 4'b1111;
        laneData = WriteDataM;
      end
      default: misM = MemWriteM | MemReadM;
    endcase
  end

  // Reset gates the write so a store overlapping reset never lands
  assign storeEn = MemWriteM & ~misM & reset;
  assign loadEn  = MemReadM & ~MemWriteM;

  // Array has no reset; only enabled lanes are written
  always_ff @(posedge clk) begin
    if (storeEn) begin
      for (int b = 0; b < 4; b++) begin
        if (laneEn[b]) mem[wordIdx][8*b +: 8] <= laneData[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rawW      <= 32'h0;
      offW      <= 2'b00;
      MisalignW <= 1'b0;
    end else begin
      MisalignW <= misM;
      if (loadEn) begin
        rawW <= misM ? 32'h0 : mem[wordIdx];
        offW <= offM;
      end
    end
  end

  // W-stage lane extraction and extension
  always_comb begin
    case (offW)
      2'b00:   byteVal = rawW[7:0];
      2'b01:   byteVal = rawW[15:8];
      2'b10:   byteVal = rawW[23:16];
      default: byteVal = rawW[31:24];
    endcase
    halfVal = offW[1] ? rawW[31:16] : rawW[15:0];
    case (ByteSrcW)
      3'b000:  ReadDataW = {{24{byteVal[7]}}, byteVal};
      3'b100:  ReadDataW = {24'h0, byteVal};
      3'b001:  ReadDataW = {{16{halfVal[15]}}, halfVal};
      3'b101:  ReadDataW = {16'h0, halfVal};
      default: ReadDataW = rawW;
    endcase
  end

endmodule

// File: tb/tb_dmem_bram_port.sv
// Directed vector-table bench for dmem_bram_port plus hand-written reset sequences.
module tb_dmem_bram_port;

  logic        clk;
  logic        reset;
  logic        MemWriteM;
  logic        MemReadM;
  logic [1:0]  ByteAccessM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [2:0]  ByteSrcW;
  logic [31:0] ReadDataW;
  logic        MisalignW;

  int nTests = 0;
  int nFail  = 0;

  dmem_bram_port #(.DEPTH_WORDS(1024), .AW(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemWriteM  (MemWriteM),
    .MemReadM   (MemReadM),
    .ByteAccessM(ByteAccessM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .ByteSrcW   (ByteSrcW),
    .ReadDataW  (ReadDataW),
    .MisalignW  (MisalignW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic        re;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [2:0]  src;
    logic        chkD;
    logic [31:0] expD;
    logic        expM;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input string name, input logic we, input logic re, input logic [1:0] sz,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] src,
                        input logic chkD, input logic [31:0] expD, input logic expM);
    vec_t v;
    v.name = name; v.we = we; v.re = re; v.sz = sz; v.addr = addr; v.wd = wd;
    v.src = src; v.chkD = chkD; v.expD = expD; v.expM = expM;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic driveM(input logic we, input logic re, input logic [1:0] sz,
                        input logic [31:0] addr, input logic [31:0] wd);
    MemWriteM = we; MemReadM = re; ByteAccessM = sz; ALUResultM = addr; WriteDataM = wd;
  endtask

  task automatic idleM();
    driveM(1'b0, 1'b0, 2'b10, 32'h0, 32'h0);
  endtask

  initial begin
    reset = 1'b0;
    idleM();
    ByteSrcW = 3'b010;
    #2;
    check("reset_data", ReadDataW, 32'h0);
    check("reset_mis", {31'h0, MisalignW}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // sw/lw/sh/sb encodings: sz 10 word, 01 half, 00 byte, 11 reserved
    addVec("sw_10",       1, 0, 2'b10, 32'h10,   32'hDEADBEEF, 3'b010, 0, 32'h0,        0);
    addVec("lw_10",       0, 1, 2'b10, 32'h10,   32'h0,        3'b010, 1, 32'hDEADBEEF, 0);
    addVec("idle_hold",   0, 0, 2'b10, 32'h0,    32'h0,        3'b010, 1, 32'hDEADBEEF, 0);
    addVec("sw_20",       1, 0, 2'b10, 32'h20,   32'h11223344, 3'b010, 0, 32'h0,        0);
    addVec("sb_22",       1, 0, 2'b00, 32'h22,   32'h000000AA, 3'b010, 0, 32'h0,        0);
    addVec("sh_20",       1, 0, 2'b01, 32'h20,   32'h0000BBCC, 3'b010, 0, 32'h0,        0);
    addVec("lw_20",       0, 1, 2'b10, 32'h20,   32'h0,        3'b010, 1, 32'h11AABBCC, 0);
    addVec("sw_30",       1, 0, 2'b10, 32'h30,   32'h80F07F01, 3'b010, 0, 32'h0,        0);
    addVec("lb_33",       0, 1, 2'b00, 32'h33,   32'h0,        3'b000, 1, 32'hFFFFFF80, 0);
    addVec("lbu_33",      0, 1, 2'b00, 32'h33,   32'h0,        3'b100, 1, 32'h00000080, 0);
    addVec("lh_32",       0, 1, 2'b01, 32'h32,   32'h0,        3'b001, 1, 32'hFFFF80F0, 0);
    addVec("lhu_30",      0, 1, 2'b01, 32'h30,   32'h0,        3'b101, 1, 32'h00007F01, 0);
    addVec("lb_30",       0, 1, 2'b00, 32'h30,   32'h0,        3'b000, 1, 32'h00000001, 0);
    addVec("src110_30",   0, 1, 2'b10, 32'h30,   32'h0,        3'b110, 1, 32'h80F07F01, 0);
    addVec("sw_40",       1, 0, 2'b10, 32'h40,   32'h0A0B0C0D, 3'b010, 0, 32'h0,        0);
    addVec("sw_mis_41",   1, 0, 2'b10, 32'h41,   32'h12345678, 3'b010, 0, 32'h0,        1);
    addVec("sw_rsv_40",   1, 0, 2'b11, 32'h40,   32'hFFFFFFFF, 3'b010, 0, 32'h0,        1);
    addVec("lw_40_keep",  0, 1, 2'b10, 32'h40,   32'h0,        3'b010, 1, 32'h0A0B0C0D, 0);
    addVec("lh_mis_43",   0, 1, 2'b01, 32'h43,   32'h0,        3'b001, 1, 32'h0,        1);
    addVec("lw_40_again", 0, 1, 2'b10, 32'h40,   32'h0,        3'b010, 1, 32'h0A0B0C0D, 0);
    addVec("ld_rsv_44",   0, 1, 2'b11, 32'h44,   32'h0,        3'b010, 1, 32'h0,        1);
    addVec("sw_1000",     1, 0, 2'b10, 32'h1000, 32'hCAFE0001, 3'b010, 0, 32'h0,        0);
    addVec("lw_0_wrap",   0, 1, 2'b10, 32'h0,    32'h0,        3'b010, 1, 32'hCAFE0001, 0);
    addVec("lw_1010",     0, 1, 2'b10, 32'h1010, 32'h0,        3'b010, 1, 32'hDEADBEEF, 0);
    addVec("sw_4",        1, 0, 2'b10, 32'h4,    32'h11111111, 3'b010, 0, 32'h0,        0);
    addVec("sw_8",        1, 0, 2'b10, 32'h8,    32'h22222222, 3'b010, 0, 32'h0,        0);
    addVec("sw_c",        1, 0, 2'b10, 32'hC,    32'h33333333, 3'b010, 0, 32'h0,        0);
    addVec("stream_0",    0, 1, 2'b10, 32'h0,    32'h0,        3'b010, 1, 32'hCAFE0001, 0);
    addVec("stream_4",    0, 1, 2'b10, 32'h4,    32'h0,        3'b010, 1, 32'h11111111, 0);
    addVec("stream_8",    0, 1, 2'b10, 32'h8,    32'h0,        3'b010, 1, 32'h22222222, 0);
    addVec("stream_c",    0, 1, 2'b10, 32'hC,    32'h0,        3'b010, 1, 32'h33333333, 0);

    @(posedge clk); #2;
    foreach (vecs[i]) begin
      driveM(vecs[i].we, vecs[i].re, vecs[i].sz, vecs[i].addr, vecs[i].wd);
      @(posedge clk); #1;
      ByteSrcW = vecs[i].src;
      #1;
      check({vecs[i].name, "_mis"}, {31'h0, MisalignW}, {31'h0, vecs[i].expM});
      if (vecs[i].chkD) check(vecs[i].name, ReadDataW, vecs[i].expD);
    end

    // Asynchronous reset mid-cycle with loaded data and a pending misalign flag
    driveM(1'b1, 1'b0, 2'b10, 32'h14, 32'h5555AAA5);
    @(posedge clk); #2;
    driveM(1'b0, 1'b1, 2'b10, 32'h14, 32'h0);
    @(posedge clk); #1;
    ByteSrcW = 3'b000;
    #1;
    check("pre_rst_lb", ReadDataW, 32'hFFFFFFA5);
    driveM(1'b1, 1'b0, 2'b10, 32'h15, 32'hFFFFFFFF);
    @(posedge clk); #2;
    check("pre_rst_hold", ReadDataW, 32'hFFFFFFA5);
    check("pre_rst_mis", {31'h0, MisalignW}, 32'h1);
    driveM(1'b1, 1'b0, 2'b10, 32'h14, 32'hDEAD0000);
    #1;
    reset = 1'b0;
    #1;
    check("rst_async_data", ReadDataW, 32'h0);
    check("rst_async_mis", {31'h0, MisalignW}, 32'h0);
    @(posedge clk); #2;
    check("rst_held_data", ReadDataW, 32'h0);
    idleM();
    @(negedge clk);
    reset = 1'b1;
    driveM(1'b0, 1'b1, 2'b10, 32'h14, 32'h0);
    @(posedge clk); #1;
    ByteSrcW = 3'b010;
    #1;
    check("post_rst_w5", ReadDataW, 32'h5555AAA5);
    check("post_rst_mis", {31'h0, MisalignW}, 32'h0);
    idleM();
    @(posedge clk); #2;

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/dmem_bram_port.md
# dmem_bram_port

Data-memory responder for the pipelined RISC-V core: the memory-side end of the M/W-stage memory control signals issued by the registered control unit. It holds a word-organised synchronous BRAM array and commits byte/halfword/word stores with byte enables at the end of M. It issues synchronous reads in M and returns the W-stage load value, extracted and sign- or zero-extended per the load type. It also flags misaligned accesses one cycle later, alongside the load data.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words in the array (power of two).
- AW, 32: address width of ALUResultM.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (reset = 0 resets).
- MemWriteM  in  1  store in M.
- MemReadM  in  1  load in M. Never asserted together with MemWriteM; if both are asserted, the store wins.
- ByteAccessM  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
- ALUResultM  in  AW  byte address.
- WriteDataM  in  32  store data, right-aligned.
- ByteSrcW  in  3  load type in W, funct3 encoding: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
- ReadDataW  out  32  extracted, extended load result.
- MisalignW  out  1  misaligned or reserved-size access was in M last cycle.

## Operation
- Word index = ALUResultM[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so accesses wrap modulo the array size.
- Offset = ALUResultM[1:0].
- Misaligned in M when any of these holds:
  - half access with offset[0] = 1;
  - word access with offset ≠ 00;
  - ByteAccessM = 11 with MemWriteM or MemReadM asserted.
- Store (MemWriteM = 1, aligned, reset high), byte enables:
  - byte: lane = offset, data WriteDataM[7:0] placed in that lane.
  - half: lanes {2·offset[1]+1, 2·offset[1]}, data WriteDataM[15:0].
  - word: all four lanes, WriteDataM.
  - Disabled lanes are unchanged.
- Misaligned store: no lanes written.
- Load (MemReadM = 1): the array word at the index is captured into rawW at the clock edge, and offset is captured into offW.
  - A misaligned load captures rawW = 0.
  - rawW and offW hold when no load is in M.
- W extraction (combinational from rawW, offW, ByteSrcW):
  - lb/lbu: byte at lane offW, sign/zero-extended.
  - lh/lhu: half at lanes 2·offW[1]+1 : 2·offW[1], sign/zero-extended.
  - lw: rawW.
  - 011/110/111: rawW.
- MisalignW = registered misalign of M; updates every cycle.
- Array contents are not reset. Simulation initialises them to 0.

## Timing
- Store: written at the rising edge that ends the M cycle. Visible to a load issued in the next cycle's M.
- Load latency: 1 clock. Address in M at edge t, ReadDataW valid during W after edge t.
- Back-to-back loads: one per cycle, no bubbles.
- Store-then-load to the same word on consecutive cycles returns the new data. No forwarding needed, because the store has committed before the load's read edge.
- Reset asserted (asynchronous, at any time):
  - rawW = 0, offW = 00, MisalignW = 0, hence ReadDataW = 0.
  - A store coincident with reset low is suppressed.
- Reset deassertion: the first active edge after reset rises performs normal M-stage work.

## Test plan
- Reset: drive reset = 0 mid-load, with ByteSrcW = 000 -> ReadDataW = 0 and MisalignW = 0 immediately. Array word 5 (written earlier) still reads back its value after release.
- Word round trip: sw 0xDEADBEEF @0x10, then lw @0x10 next cycle -> ReadDataW = 0xDEADBEEF one cycle after the load, MisalignW = 0.
- Sub-word stores: sw 0x11223344 @0x20, sb 0xAA @0x22, sh 0xBBCC @0x20; lw @0x20 -> 0x11AABBCC.
- Extension: word @0x30 = 0x80F07F01.
  - lb @0x33 -> 0xFFFFFF80.
  - lbu @0x33 -> 0x00000080.
  - lh @0x32 -> 0xFFFF80F0.
  - lhu @0x30 -> 0x00007F01.
  - lb @0x30 -> 0x00000001.
- Misalign: sw 0x12345678 @0x41 -> MisalignW = 1 next cycle and word @0x40 unchanged. lh @0x43 -> ReadDataW = 0, MisalignW = 1. ByteAccessM = 11 load -> MisalignW = 1.
- Wrap and streaming:
  - With DEPTH_WORDS = 1024: sw 0xCAFE0001 @0x1000, then lw @0x0 -> 0xCAFE0001.
  - Four consecutive lw @0x0, 0x4, 0x8, 0xC return their four words on four consecutive cycles.
